bram_fifo_sc: RTL and testbench

Single-clock, BRAM-backed FIFO for same-domain buffering, e.g. BT.656 line data ahead of the AST stream packer.
Parametrised in data width and depth, with:
- standard or first-word-fall-through (FWFT) read mode
- occupancy count
- programmable almost-full/almost-empty margins
- sticky overflow/underflow error flags
Full/empty detection uses plain binary counters; no Gray-code pointers.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/BRAM2.sv | 30 +++
 rtl/bram_fifo_sc.sv | 106 ++++++++++
 tb/tb_bram_fifo_sc.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO: read-mode selectors and the
// capacity helper used to size RAM and occupancy thresholds.
package fifo_pkg;

  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON  = 1'b1;

  function automatic int fifo_depth(input int addr_len);
    return 1 << addr_len;
  endfunction

endpackage

// File: rtl/BRAM2.sv
// Simple dual-port block RAM: port 0 is a registered read port with an
// output-register reset, port 1 is the write port.
module BRAM2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LEN   = 10
) (
  input  logic                  CLK0,
  input  logic                  RST0,
  input  logic                  EN0,
  input  logic [ADDR_LEN-1:0]   ADDR0,
  output logic [DATA_WIDTH-1:0] Q0,
  input  logic                  CLK1,
  input  logic                  WE1,
  input  logic [ADDR_LEN-1:0]   ADDR1,
  input  logic [DATA_WIDTH-1:0] D1
);

  // NOTE: the storage array has no reset so it maps onto block RAM; only the output register is cleared.
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_LEN)-1];

  always_ff @(posedge CLK1) begin
    if (WE1) mem[ADDR1] <= D1;
  end

  always_ff @(posedge CLK0) begin
    if (RST0)     Q0 <= '0;
    else if (EN0) Q0 <= mem[ADDR0];
  end

endmodule

// File: rtl/bram_fifo_sc.sv
// Single-clock BRAM-backed FIFO with standard or first-word-fall-through reads,
// occupancy count, almost-full/almost-empty margins and sticky error flags.
module bram_fifo_sc
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_LEN         = 10,
  parameter bit FWFT             = FWFT_OFF,
  parameter int ALM_FULL_MARGIN  = 4,
  parameter int ALM_EMPTY_MARGIN = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  ENQ,
  output logic                  FULL,
  output logic                  ALM_FULL,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  DEQ,
  output logic                  EMPTY,
  output logic                  ALM_EMPTY,
  output logic [ADDR_LEN:0]     COUNT,
  output logic                  OVF,
  output logic                  UDF,
  input  logic                  CLR_ERR
);

  localparam int                DEPTH   = fifo_depth(ADDR_LEN);
  localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0] CNT_ONE = (ADDR_LEN+1)'(1);
  localparam logic [ADDR_LEN-1:0] PTR_ONE = ADDR_LEN'(1);

  logic [ADDR_LEN-1:0] wptr, rptr;
  logic [ADDR_LEN:0]   count, count_nxt;
  logic full_r, alm_full_r, empty_r, alm_empty_r, ovf_r, udf_r, q_valid;
  logic wr_acc, rd_acc, ram_rd, ram_has_data, q_valid_nxt, empty_nxt;

  assign wr_acc = ENQ && !full_r;
  assign rd_acc = DEQ && !empty_r;

  // In FWFT mode the BRAM output register is the one-entry output stage, so
  // one word of COUNT may already have left the RAM.
  assign ram_has_data = (count != (ADDR_LEN+1)'(q_valid));
  assign ram_rd       = FWFT ? ((!q_valid || rd_acc) && ram_has_data) : rd_acc;
  assign q_valid_nxt  = ram_rd || (q_valid && !rd_acc);

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CNT_ONE;
    else if (rd_acc && !wr_acc) count_nxt = count - CNT_ONE;
    empty_nxt = FWFT ? !q_valid_nxt : (count_nxt == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full_r      <= 1'b0;
      alm_full_r  <= (ALM_FULL_MARGIN >= DEPTH);
      empty_r     <= 1'b1;
      alm_empty_r <= 1'b1;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
      q_valid     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (ram_rd) rptr <= rptr + PTR_ONE;
      count       <= count_nxt;
      full_r      <= (count_nxt == DEPTH_C);
      alm_full_r  <= (int'(count_nxt) >= DEPTH - ALM_FULL_MARGIN);
      alm_empty_r <= (int'(count_nxt) <= ALM_EMPTY_MARGIN);
      empty_r     <= empty_nxt;
      q_valid     <= q_valid_nxt;
      // A new error in the same cycle as CLR_ERR keeps the flag set.
      ovf_r       <= (ENQ && full_r)  || (ovf_r && !CLR_ERR);
      udf_r       <= (DEQ && empty_r) || (udf_r && !CLR_ERR);
    end
  end

  BRAM2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_LEN   (ADDR_LEN)
  ) u_ram (
    .CLK0  (CLK),
    .RST0  (RST),
    .EN0   (ram_rd),
    .ADDR0 (rptr),
    .Q0    (Q),
    .CLK1  (CLK),
    .WE1   (wr_acc),
    .ADDR1 (wptr),
    .D1    (D)
  );

  assign FULL      = full_r;
  assign ALM_FULL  = alm_full_r;
  assign EMPTY     = empty_r;
  assign ALM_EMPTY = alm_empty_r;
  assign COUNT     = count;
  assign OVF       = ovf_r;
  assign UDF       = udf_r;

endmodule

// File: tb/tb_bram_fifo_sc.sv
// Bench for bram_fifo_sc: a standard-mode and an FWFT instance share stimulus and
// are compared against queue-based reference models.
module tb_bram_fifo_sc;
  import fifo_pkg::*;

  localparam int DW    = 32;
  localparam int AL    = 4;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST = 1'b1, ENQ = 1'b0, DEQ = 1'b0, CLR_ERR = 1'b0;
  logic [DW-1:0] D = '0;

  logic          s_full, s_alm_full, s_empty, s_alm_empty, s_ovf, s_udf;
  logic          f_full, f_alm_full, f_empty, f_alm_empty, f_ovf, f_udf;
  logic [DW-1:0] s_q, f_q;
  logic [AL:0]   s_count, f_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: queues of stored words, plus FWFT head visibility.
  logic [DW-1:0] ms_q[$];
  logic [DW-1:0] mf_q[$];
  logic [DW-1:0] ms_qout = '0;
  bit ms_qknown = 0, mf_vis = 0, ms_ovf = 0, ms_udf = 0, mf_ovf = 0, mf_udf = 0;

  bram_fifo_sc #(.DATA_WIDTH(DW), .ADDR_LEN(AL), .FWFT(FWFT_OFF),
                 .ALM_FULL_MARGIN(4), .ALM_EMPTY_MARGIN(2)) dut_std (
    .CLK(CLK), .RST(RST), .D(D), .ENQ(ENQ), .FULL(s_full), .ALM_FULL(s_alm_full),
    .Q(s_q), .DEQ(DEQ), .EMPTY(s_empty), .ALM_EMPTY(s_alm_empty), .COUNT(s_count),
    .OVF(s_ovf), .UDF(s_udf), .CLR_ERR(CLR_ERR));

  bram_fifo_sc #(.DATA_WIDTH(DW), .ADDR_LEN(AL), .FWFT(FWFT_ON),
                 .ALM_FULL_MARGIN(4), .ALM_EMPTY_MARGIN(2)) dut_fwft (
    .CLK(CLK), .RST(RST), .D(D), .ENQ(ENQ), .FULL(f_full), .ALM_FULL(f_alm_full),
    .Q(f_q), .DEQ(DEQ), .EMPTY(f_empty), .ALM_EMPTY(f_alm_empty), .COUNT(f_count),
    .OVF(f_ovf), .UDF(f_udf), .CLR_ERR(CLR_ERR));

  task automatic model_edge(input bit enq, input bit deq, input bit clr, input bit rst,
                            input logic [DW-1:0] d);
    bit was_full, was_empty;
    if (rst) begin
      ms_q.delete(); mf_q.delete();
      ms_qknown = 0; mf_vis = 0;
      ms_ovf = 0; ms_udf = 0; mf_ovf = 0; mf_udf = 0;
      return;
    end
    was_full  = (ms_q.size() == DEPTH);
    was_empty = (ms_q.size() == 0);
    if (deq && !was_empty) begin ms_qout = ms_q.pop_front(); ms_qknown = 1; end
    if (enq && !was_full) ms_q.push_back(d);
    ms_ovf = (enq && was_full)  || (ms_ovf && !clr);
    ms_udf = (deq && was_empty) || (ms_udf && !clr);
    // FWFT: a word becomes visible one edge after it was stored.
    was_full  = (mf_q.size() == DEPTH);
    was_empty = !mf_vis;
    if (deq && mf_vis) void'(mf_q.pop_front());
    mf_vis = (mf_q.size() > 0);
    if (enq && !was_full) mf_q.push_back(d);
    mf_ovf = (enq && was_full)  || (mf_ovf && !clr);
    mf_udf = (deq && was_empty) || (mf_udf && !clr);
  endtask

  task automatic step(input bit enq, input bit deq, input bit clr, input bit rst,
                      input logic [DW-1:0] d);
    ENQ = enq; DEQ = deq; CLR_ERR = clr; RST = rst; D = d;
    @(posedge CLK);
    model_edge(enq, deq, clr, rst, d);
    #1;
    ENQ = 1'b0; DEQ = 1'b0; CLR_ERR = 1'b0; RST = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 1, 32'h55);
    step(0, 0, 0, 1, 0);
    n_checks++;
    if ({s_count, s_empty, s_alm_empty, s_full, s_alm_full, s_ovf, s_udf} !== {5'd0, 6'b110000}) begin
      n_fail++;
      $display("FAIL reset_std: got cnt=%0d e=%b ae=%b f=%b af=%b o=%b u=%b want cnt=0 e=1 ae=1 f=0 af=0 o=0 u=0",
               s_count, s_empty, s_alm_empty, s_full, s_alm_full, s_ovf, s_udf);
    end
    n_checks++;
    if ({f_count, f_empty, f_alm_empty, f_full, f_q} !== {5'd0, 3'b110, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_fwft: got cnt=%0d e=%b ae=%b f=%b q=%h want cnt=0 e=1 ae=1 f=0 q=0",
               f_count, f_empty, f_alm_empty, f_full, f_q);
    end
  endtask

  task automatic test_single();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 32'hA5);
    n_checks++;
    if ({s_empty, s_count} !== {1'b0, 5'd1}) begin
      n_fail++; $display("FAIL single_write_std: got e=%b cnt=%0d want e=0 cnt=1", s_empty, s_count);
    end
    n_checks++;
    if ({f_empty, f_count} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL single_write_fwft: got e=%b cnt=%0d want e=1 cnt=1", f_empty, f_count);
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if ({s_q, s_empty, s_count} !== {32'hA5, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL single_read_std: got q=%h e=%b cnt=%0d want q=a5 e=1 cnt=0", s_q, s_empty, s_count);
    end
    n_checks++;
    if ({f_q, f_empty} !== {32'hA5, 1'b0}) begin
      n_fail++; $display("FAIL single_show_fwft: got q=%h e=%b want q=a5 e=0", f_q, f_empty);
    end
  endtask

  task automatic test_fill();
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 0, 0, DW'(i));
      n_checks++;
      if ({s_count, s_alm_full, s_full, f_count, f_alm_full, f_full} !==
          {5'(i), i >= 12, i == DEPTH, 5'(i), i >= 12, i == DEPTH}) begin
        n_fail++;
        $display("FAIL fill_%0d: got s cnt=%0d af=%b f=%b, f cnt=%0d af=%b f=%b want cnt=%0d af=%b f=%b",
                 i, s_count, s_alm_full, s_full, f_count, f_alm_full, f_full, i, i >= 12, i == DEPTH);
      end
    end
    step(1, 0, 0, 0, 32'h77);
    n_checks++;
    if ({s_ovf, s_count, f_ovf, f_count} !== {1'b1, 5'd16, 1'b1, 5'd16}) begin
      n_fail++; $display("FAIL overflow: got s o=%b cnt=%0d f o=%b cnt=%0d want o=1 cnt=16",
                         s_ovf, s_count, f_ovf, f_count);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++;
      if ({f_q, f_empty} !== {DW'(i), 1'b0}) begin
        n_fail++; $display("FAIL drain_fwft_%0d: got q=%h e=%b want q=%h e=0", i, f_q, f_empty, DW'(i));
      end
      step(0, 1, 0, 0, 0);
      n_checks++;
      if ({s_q, s_alm_empty} !== {DW'(i), DEPTH - i <= 2}) begin
        n_fail++; $display("FAIL drain_std_%0d: got q=%h ae=%b want q=%h ae=%b",
                           i, s_q, s_alm_empty, DW'(i), DEPTH - i <= 2);
      end
    end
    n_checks++;
    if ({s_empty, s_count, f_empty, f_count} !== {1'b1, 5'd0, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL drained_empty: got s e=%b cnt=%0d f e=%b cnt=%0d want e=1 cnt=0",
                         s_empty, s_count, f_empty, f_count);
    end
  endtask

  task automatic test_full_enq_deq();
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 0, DW'(i));
    step(1, 1, 0, 0, 32'hDEAD);
    n_checks++;
    if ({s_count, s_full, s_ovf, s_q} !== {5'd15, 1'b0, 1'b1, 32'd1}) begin
      n_fail++; $display("FAIL full_rw_std: got cnt=%0d f=%b o=%b q=%h want cnt=15 f=0 o=1 q=1",
                         s_count, s_full, s_ovf, s_q);
    end
    n_checks++;
    if ({f_count, f_full, f_ovf} !== {5'd15, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL full_rw_fwft: got cnt=%0d f=%b o=%b want cnt=15 f=0 o=1", f_count, f_full, f_ovf);
    end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if ({s_ovf, f_ovf} !== 2'b00) begin
      n_fail++; $display("FAIL clr_err: got s o=%b f o=%b want 0 0", s_ovf, f_ovf);
    end
    for (int i = 2; i <= DEPTH; i++) begin
      step(0, 1, 0, 0, 0);
      n_checks++;
      if (s_q !== DW'(i)) begin
        n_fail++; $display("FAIL full_rw_drain_%0d: got q=%h want q=%h", i, s_q, DW'(i));
      end
    end
    n_checks++;
    if ({s_empty, f_empty, s_udf, f_udf} !== 4'b1100) begin
      n_fail++; $display("FAIL full_rw_end: got se=%b fe=%b su=%b fu=%b want 1 1 0 0", s_empty, f_empty, s_udf, f_udf);
    end
  endtask

  task automatic test_fwft_stream();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 32'h3C);
    n_checks++;
    if ({f_empty, f_count} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL fwft_latency_n: got e=%b cnt=%0d want e=1 cnt=1", f_empty, f_count);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({f_empty, f_q} !== {1'b0, 32'h3C}) begin
      n_fail++; $display("FAIL fwft_latency_n1: got e=%b q=%h want e=0 q=3c", f_empty, f_q);
    end
    step(1, 0, 0, 0, 32'd0);
    for (int i = 1; i <= 99; i++) begin
      n_checks++;
      if ({f_empty, f_q} !== {1'b0, (i == 1) ? 32'h3C : DW'(i - 2)}) begin
        n_fail++; $display("FAIL fwft_stream_q_%0d: got e=%b q=%h want e=0 q=%h",
                           i, f_empty, f_q, (i == 1) ? 32'h3C : DW'(i - 2));
      end
      step(1, 1, 0, 0, DW'(i));
      n_checks++;
      if (f_count !== 5'd2) begin
        n_fail++; $display("FAIL fwft_stream_cnt_%0d: got %0d want 2", i, f_count);
      end
    end
    for (int i = 98; i <= 99; i++) begin
      n_checks++;
      if (f_q !== DW'(i)) begin
        n_fail++; $display("FAIL fwft_tail_%0d: got q=%h want q=%h", i, f_q, DW'(i));
      end
      step(0, 1, 0, 0, 0);
    end
    n_checks++;
    if ({f_empty, f_count, f_udf} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL fwft_stream_end: got e=%b cnt=%0d u=%b want e=1 cnt=0 u=0", f_empty, f_count, f_udf);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, $urandom);
    n_checks++;
    if ({s_count, s_udf, f_count, f_udf} !== {5'd7, 1'b1, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset: got s cnt=%0d u=%b f cnt=%0d u=%b want cnt=7 u=1", s_count, s_udf, f_count, f_udf);
    end
    step(1, 1, 0, 1, 32'hFFFF);
    n_checks++;
    if ({s_count, s_empty, s_alm_empty, s_ovf, s_udf, f_count, f_empty, f_alm_empty, f_ovf, f_udf, f_q} !==
        {5'd0, 4'b1100, 5'd0, 4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL mid_reset: got s cnt=%0d e=%b ae=%b o=%b u=%b f cnt=%0d e=%b ae=%b o=%b u=%b q=%h want 0 1 1 0 0 / 0 1 1 0 0 0",
                         s_count, s_empty, s_alm_empty, s_ovf, s_udf, f_count, f_empty, f_alm_empty, f_ovf, f_udf, f_q);
    end
    step(1, 0, 0, 0, 32'h1234);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (f_q !== 32'h1234) begin
      n_fail++; $display("FAIL post_reset_fwft: got q=%h want q=1234", f_q);
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (s_q !== 32'h1234) begin
      n_fail++; $display("FAIL post_reset_std: got q=%h want q=1234", s_q);
    end
  endtask

  task automatic test_udf_wrap();
    int reads, cyc;
    bit en, de, cl;
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    n_checks++;
    if ({s_udf, s_count, f_udf, f_count} !== {1'b1, 5'd0, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL underflow: got s u=%b cnt=%0d f u=%b cnt=%0d want u=1 cnt=0", s_udf, s_count, f_udf, f_count);
    end
    step(1, 0, 0, 0, 32'hBEEF);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    n_checks++;
    if ({s_q, f_q} !== {32'hBEEF, 32'hBEEF}) begin
      n_fail++; $display("FAIL udf_ptr_hold: got s q=%h f q=%h want beef", s_q, f_q);
    end
    reads = 0;
    cyc   = 0;
    while ((reads < 3 * DEPTH || cyc < 300) && cyc < 3000) begin
      // Alternate fill-biased and drain-biased phases so both ends are exercised.
      if ((cyc / 48) % 2 == 0) begin en = ($urandom_range(0, 9) < 8); de = ($urandom_range(0, 9) < 4); end
      else                     begin en = ($urandom_range(0, 9) < 4); de = ($urandom_range(0, 9) < 8); end
      cl = ($urandom_range(0, 15) == 0);
      if (de && ms_q.size() > 0) reads++;
      step(en, de, cl, 0, $urandom);
      cyc++;
      n_checks++;
      if ({s_count, s_empty, s_full, s_alm_full, s_alm_empty, s_ovf, s_udf} !==
          {5'(ms_q.size()), ms_q.size() == 0, ms_q.size() == DEPTH, ms_q.size() >= DEPTH - 4,
           ms_q.size() <= 2, ms_ovf, ms_udf}) begin
        n_fail++; $display("FAIL rand_std_c%0d: got cnt=%0d e=%b f=%b af=%b ae=%b o=%b u=%b want cnt=%0d o=%b u=%b",
                           cyc, s_count, s_empty, s_full, s_alm_full, s_alm_empty, s_ovf, s_udf, ms_q.size(), ms_ovf, ms_udf);
      end
      n_checks++;
      if ({f_count, f_empty, f_full, f_alm_full, f_alm_empty, f_ovf, f_udf} !==
          {5'(mf_q.size()), !mf_vis, mf_q.size() == DEPTH, mf_q.size() >= DEPTH - 4,
           mf_q.size() <= 2, mf_ovf, mf_udf}) begin
        n_fail++; $display("FAIL rand_fwft_c%0d: got cnt=%0d e=%b f=%b af=%b ae=%b o=%b u=%b want cnt=%0d e=%b o=%b u=%b",
                           cyc, f_count, f_empty, f_full, f_alm_full, f_alm_empty, f_ovf, f_udf, mf_q.size(), !mf_vis, mf_ovf, mf_udf);
      end
      if (ms_qknown) begin
        n_checks++;
        if (s_q !== ms_qout) begin
          n_fail++; $display("FAIL rand_std_q_c%0d: got %h want %h", cyc, s_q, ms_qout);
        end
      end
      if (mf_vis) begin
        n_checks++;
        if (f_q !== mf_q[0]) begin
          n_fail++; $display("FAIL rand_fwft_q_c%0d: got %h want %h", cyc, f_q, mf_q[0]);
        end
      end
    end
    n_checks++;
    if (reads < 3 * DEPTH) begin
      n_fail++; $display("FAIL wrap_budget: got %0d reads want at least %0d", reads, 3 * DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_enq_deq();
    test_fwft_stream();
    test_reset_mid();
    test_udf_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
